// File: rtl/tdc_pkg.sv
// Shared types and default parameters for the multi-channel TDC stop synchroniser.
package tdc_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } coll_state_t;

   localparam int TDC_CH          = 4;
   localparam int TDC_SYNC_STAGES = 2;
   localparam int TDC_CNT_W       = 16;

endpackage

// File: rtl/tdc_sync_ch.sv
// One channel: dual-edge trigger sampling, phase select, synchroniser chain, rising-edge detect.
// rise is combinational from the last two posedge stages; the channel never stalls.
module tdc_sync_ch #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk5,
   input  logic rst_n,
   input  logic trigger,
   input  logic s,
   output logic sync,
   output logic rise
);

   logic stop_n;
   logic stop_p;
   logic vout;
   logic qs;
   logic qd;

   assign vout = s ? stop_p : stop_n;

   always_ff @(negedge clk5 or negedge rst_n) begin
      if (!rst_n) begin
         stop_n <= 1'b0;
         sync   <= 1'b0;
      end else begin
         stop_n <= trigger;
         sync   <= vout;
      end
   end

   always_ff @(posedge clk5 or negedge rst_n) begin
      if (!rst_n) begin
         stop_p <= 1'b0;
         qd     <= 1'b0;
      end else begin
         stop_p <= trigger;
         qd     <= qs;
      end
   end

   // The negedge sync flop is stage 1; any further stages are posedge flops.
   if (SYNC_STAGES == 1) begin : g_no_chain
      assign qs = sync;
   end else begin : g_chain
      logic [SYNC_STAGES-2:0] q;

      always_ff @(posedge clk5 or negedge rst_n) begin
         if (!rst_n) begin
            q <= '0;
         end else begin
            q[0] <= sync;
            for (int k = 1; k < SYNC_STAGES - 1; k++) begin
               q[k] <= q[k-1];
            end
         end
      end

      assign qs = q[SYNC_STAGES-2];
   end

   assign rise = qs & ~qd;

endmodule

// File: rtl/tdc_sync_multi.sv
// Multi-channel TDC stop synchroniser with hit collector: hit_valid SYNC_STAGES (+1 for s=0) posedges after trigger.
// While hit_ready is low the event is held stable and new hits merge into a pending mask; repeats set sticky ovf.
module tdc_sync_multi
   import tdc_pkg::*;
#(
   parameter int CH          = TDC_CH,
   parameter int SYNC_STAGES = TDC_SYNC_STAGES,
   parameter int CNT_W       = TDC_CNT_W
) (
   input  logic             clk5,
   input  logic             rst_n,
   input  logic [CH-1:0]    TDC_trigger,
   input  logic [CH-1:0]    s,
   input  logic             en,
   output logic [CH-1:0]    sync,
   output logic             hit_valid,
   input  logic             hit_ready,
   output logic [CH-1:0]    hit_mask,
   output logic [CNT_W-1:0] hit_time,
   output logic [CH-1:0]    ovf,
   input  logic             ovf_clr
);

   logic [CH-1:0]    rise;
   logic [CH-1:0]    rise_en;
   logic [CH-1:0]    merged;
   logic [CH-1:0]    pend_mask;
   logic [CH-1:0]    pend_mask_nxt;
   logic [CH-1:0]    hit_mask_nxt;
   logic [CH-1:0]    ovf_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] pend_time;
   logic [CNT_W-1:0] pend_time_nxt;
   logic [CNT_W-1:0] hit_time_nxt;
   logic             hit_valid_nxt;
   coll_state_t      state;
   coll_state_t      state_nxt;

   for (genvar i = 0; i < CH; i++) begin : g_ch
      tdc_sync_ch #(
         .SYNC_STAGES (SYNC_STAGES)
      ) u_ch (
         .clk5    (clk5),
         .rst_n   (rst_n),
         .trigger (TDC_trigger[i]),
         .s       (s[i]),
         .sync    (sync[i]),
         .rise    (rise[i])
      );
   end

   // Edges seen while disabled are dropped, not deferred.
   assign rise_en = rise & {CH{en}};
   assign merged  = pend_mask | rise_en;

   always_ff @(posedge clk5 or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + 1'b1;
      end
   end

   always_comb begin
      state_nxt     = state;
      hit_valid_nxt = hit_valid;
      hit_mask_nxt  = hit_mask;
      hit_time_nxt  = hit_time;
      pend_mask_nxt = pend_mask;
      pend_time_nxt = pend_time;
      ovf_nxt       = ovf_clr ? '0 : ovf;

      case (state)
         IDLE: begin
            if (rise_en != '0) begin
               hit_mask_nxt  = rise_en;
               hit_time_nxt  = cnt;
               hit_valid_nxt = 1'b1;
               state_nxt     = HOLD;
            end
         end
         HOLD: begin
            // A set in the same cycle as ovf_clr survives the clear.
            ovf_nxt = ovf_nxt | (rise_en & pend_mask);
            if (hit_valid && hit_ready) begin
               if (merged != '0) begin
                  hit_mask_nxt  = merged;
                  hit_time_nxt  = (pend_mask != '0) ? pend_time : cnt;
                  pend_mask_nxt = '0;
               end else begin
                  hit_valid_nxt = 1'b0;
                  state_nxt     = IDLE;
               end
            end else begin
               pend_mask_nxt = merged;
               if ((pend_mask == '0) && (rise_en != '0)) begin
                  pend_time_nxt = cnt;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk5 or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         hit_valid <= 1'b0;
         hit_mask  <= '0;
         hit_time  <= '0;
         pend_mask <= '0;
         pend_time <= '0;
         ovf       <= '0;
      end else begin
         state     <= state_nxt;
         hit_valid <= hit_valid_nxt;
         hit_mask  <= hit_mask_nxt;
         hit_time  <= hit_time_nxt;
         pend_mask <= pend_mask_nxt;
         pend_time <= pend_time_nxt;
         ovf       <= ovf_nxt;
      end
   end

endmodule

// File: tb/tb_tdc_sync_multi.sv
// Self-checking bench for tdc_sync_multi: inputs change just after negedges, outputs sampled just after posedges.
module tb_tdc_sync_multi;

   logic        clk5 = 1'b0;
   logic        rst_n;
   logic [3:0]  TDC_trigger;
   logic [3:0]  s;
   logic        en;
   logic [3:0]  sync;
   logic        hit_valid;
   logic        hit_ready;
   logic [3:0]  hit_mask;
   logic [15:0] hit_time;
   logic [3:0]  ovf;
   logic        ovf_clr;

   typedef struct packed {
      logic [3:0]  mask;
      logic [15:0] tim;
   } exp_t;

   exp_t        sb[$];
   int          n_pass  = 0;
   int          n_total = 0;
   logic [15:0] m_cnt;

   tdc_sync_multi #(
      .CH          (4),
      .SYNC_STAGES (2),
      .CNT_W       (16)
   ) dut (
      .clk5        (clk5),
      .rst_n       (rst_n),
      .TDC_trigger (TDC_trigger),
      .s           (s),
      .en          (en),
      .sync        (sync),
      .hit_valid   (hit_valid),
      .hit_ready   (hit_ready),
      .hit_mask    (hit_mask),
      .hit_time    (hit_time),
      .ovf         (ovf),
      .ovf_clr     (ovf_clr)
   );

   always #5 clk5 = ~clk5;

   // Reference coarse counter, used to place stimulus at known counter values.
   always @(posedge clk5 or negedge rst_n) begin
      if (!rst_n) m_cnt <= '0;
      else if (en) m_cnt <= m_cnt + 16'd1;
   end

   task automatic do_reset();
      rst_n       = 1'b0;
      TDC_trigger = '0;
      s           = 4'b1111;
      en          = 1'b0;
      hit_ready   = 1'b0;
      ovf_clr     = 1'b0;
      sb.delete();
      repeat (2) @(negedge clk5);
      #1 rst_n = 1'b1;
   endtask

   task automatic pop_exp(output exp_t e);
      if (sb.size() > 0) e = sb.pop_front();
      else e = '1;
   endtask

   task automatic wait_valid(input int max_cyc, output int n);
      n = -1;
      for (int i = 1; i <= max_cyc; i++) begin
         @(posedge clk5); #1;
         if (hit_valid === 1'b1) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic wait_cnt(input logic [15:0] target);
      while (m_cnt != target) begin
         @(negedge clk5); #1;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; TDC_trigger = '0; s = '0; en = 1'b0; hit_ready = 1'b0; ovf_clr = 1'b0;
      @(posedge clk5); #1;
      n_total++; if (hit_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", hit_valid); else n_pass++;
      n_total++; if (hit_mask !== 4'h0) $display("FAIL rst_mask: got %h want 0", hit_mask); else n_pass++;
      n_total++; if (hit_time !== 16'h0) $display("FAIL rst_time: got %h want 0", hit_time); else n_pass++;
      n_total++; if (sync !== 4'h0) $display("FAIL rst_sync: got %h want 0", sync); else n_pass++;
      n_total++; if (ovf !== 4'h0) $display("FAIL rst_ovf: got %h want 0", ovf); else n_pass++;
      @(negedge clk5); #1 rst_n = 1'b1;
      repeat (3) @(posedge clk5); #1;
      n_total++; if (hit_valid !== 1'b0) $display("FAIL rst_idle_valid: got %b want 0", hit_valid); else n_pass++;
   endtask

   task automatic test_posedge_phase();
      exp_t e;
      int   n;
      do_reset();
      s = 4'b1111; en = 1'b1; hit_ready = 1'b1;
      wait_cnt(16'd5);
      TDC_trigger[0] = 1'b1;
      sb.push_back({4'b0001, 16'd7});
      @(posedge clk5); #1;
      n_total++; if (sync[0] !== 1'b0) $display("FAIL s1_sync_p0: got %b want 0", sync[0]); else n_pass++;
      @(negedge clk5); #1;
      n_total++; if (sync[0] !== 1'b1) $display("FAIL s1_sync_n0: got %b want 1", sync[0]); else n_pass++;
      TDC_trigger[0] = 1'b0;
      wait_valid(8, n);
      n_total++; if (n !== 2) $display("FAIL s1_latency: got %0d posedges want 2", n); else n_pass++;
      pop_exp(e);
      n_total++; if (hit_mask !== e.mask) $display("FAIL s1_mask: got %h want %h", hit_mask, e.mask); else n_pass++;
      n_total++; if (hit_time !== e.tim) $display("FAIL s1_time: got %h want %h", hit_time, e.tim); else n_pass++;
      @(posedge clk5); #1;
      n_total++; if (hit_valid !== 1'b0) $display("FAIL s1_single_event: got %b want 0", hit_valid); else n_pass++;
   endtask

   task automatic test_negedge_phase();
      exp_t e;
      int   n;
      do_reset();
      s = 4'b1110; en = 1'b1; hit_ready = 1'b1;
      wait_cnt(16'd5);
      TDC_trigger[0] = 1'b1;
      sb.push_back({4'b0001, 16'd8});
      @(negedge clk5); #1;
      n_total++; if (sync[0] !== 1'b0) $display("FAIL s0_sync_n0: got %b want 0", sync[0]); else n_pass++;
      TDC_trigger[0] = 1'b0;
      @(negedge clk5); #1;
      n_total++; if (sync[0] !== 1'b1) $display("FAIL s0_sync_n1: got %b want 1", sync[0]); else n_pass++;
      wait_valid(8, n);
      n_total++; if (n !== 2) $display("FAIL s0_latency: got %0d posedges after N1 want 2", n); else n_pass++;
      pop_exp(e);
      n_total++; if (hit_mask !== e.mask) $display("FAIL s0_mask: got %h want %h", hit_mask, e.mask); else n_pass++;
      n_total++; if (hit_time !== e.tim) $display("FAIL s0_time: got %h want %h", hit_time, e.tim); else n_pass++;
   endtask

   task automatic test_backpressure();
      exp_t        e;
      exp_t        e2;
      logic [15:0] t0;
      logic        stable;
      do_reset();
      s = 4'b1111; en = 1'b1; hit_ready = 1'b0;
      wait_cnt(16'd10);
      t0 = m_cnt;
      sb.push_back({4'b0010, 16'(t0 + 16'd2)});
      sb.push_back({4'b1100, 16'(t0 + 16'd5)});
      stable = 1'b1;
      e = '1;
      for (int k = 0; k < 10; k++) begin
         case (k)
            0: TDC_trigger = 4'b0010;
            1: TDC_trigger = 4'b0000;
            3: TDC_trigger = 4'b1100;
            4: TDC_trigger = 4'b0000;
            8: hit_ready = 1'b1;
            default: ;
         endcase
         @(posedge clk5); #1;
         if (k == 2) begin
            pop_exp(e);
            n_total++; if (hit_valid !== 1'b1) $display("FAIL bp_first_valid: got %b want 1", hit_valid); else n_pass++;
            n_total++; if (hit_mask !== e.mask) $display("FAIL bp_first_mask: got %h want %h", hit_mask, e.mask); else n_pass++;
            n_total++; if (hit_time !== e.tim) $display("FAIL bp_first_time: got %h want %h", hit_time, e.tim); else n_pass++;
         end
         if (k >= 3 && k <= 7) begin
            if (hit_valid !== 1'b1 || hit_mask !== e.mask || hit_time !== e.tim) stable = 1'b0;
         end
         if (k == 8) begin
            pop_exp(e2);
            n_total++; if (hit_valid !== 1'b1) $display("FAIL bp_second_valid: got %b want 1", hit_valid); else n_pass++;
            n_total++; if (hit_mask !== e2.mask) $display("FAIL bp_second_mask: got %h want %h", hit_mask, e2.mask); else n_pass++;
            n_total++; if (hit_time !== e2.tim) $display("FAIL bp_second_time: got %h want %h", hit_time, e2.tim); else n_pass++;
            n_total++; if (ovf !== 4'h0) $display("FAIL bp_ovf: got %h want 0", ovf); else n_pass++;
         end
         if (k == 9) begin
            n_total++; if (hit_valid !== 1'b0) $display("FAIL bp_drain: got %b want 0", hit_valid); else n_pass++;
         end
         @(negedge clk5); #1;
      end
      n_total++; if (stable !== 1'b1) $display("FAIL bp_stable: got %b want 1", stable); else n_pass++;
   endtask

   task automatic test_overflow();
      exp_t        e;
      logic [15:0] t0;
      do_reset();
      s = 4'b1111; en = 1'b1; hit_ready = 1'b0;
      wait_cnt(16'd20);
      t0 = m_cnt;
      sb.push_back({4'b0001, 16'(t0 + 16'd2)});
      sb.push_back({4'b0100, 16'(t0 + 16'd4)});
      for (int k = 0; k < 17; k++) begin
         case (k)
            0:  TDC_trigger = 4'b0001;
            2:  TDC_trigger = 4'b0100;
            4:  TDC_trigger = 4'b0100;
            9:  ovf_clr = 1'b1;
            10: ovf_clr = 1'b0;
            11: TDC_trigger = 4'b0100;
            13: ovf_clr = 1'b1;
            14: ovf_clr = 1'b0;
            15: hit_ready = 1'b1;
            default: TDC_trigger = 4'b0000;
         endcase
         @(posedge clk5); #1;
         case (k)
            2: begin
               pop_exp(e);
               n_total++; if (hit_mask !== e.mask) $display("FAIL ovf_first_mask: got %h want %h", hit_mask, e.mask); else n_pass++;
               n_total++; if (hit_time !== e.tim) $display("FAIL ovf_first_time: got %h want %h", hit_time, e.tim); else n_pass++;
            end
            5: begin
               n_total++; if (ovf !== 4'h0) $display("FAIL ovf_single_pending: got %h want 0", ovf); else n_pass++;
            end
            6: begin
               n_total++; if (ovf !== 4'b0100) $display("FAIL ovf_set: got %h want 4", ovf); else n_pass++;
            end
            8: begin
               n_total++; if (ovf !== 4'b0100) $display("FAIL ovf_sticky: got %h want 4", ovf); else n_pass++;
            end
            9: begin
               n_total++; if (ovf !== 4'h0) $display("FAIL ovf_clr: got %h want 0", ovf); else n_pass++;
            end
            13: begin
               n_total++; if (ovf !== 4'b0100) $display("FAIL ovf_set_beats_clr: got %h want 4", ovf); else n_pass++;
               n_total++; if (hit_mask !== 4'b0001) $display("FAIL ovf_held_mask: got %h want 1", hit_mask); else n_pass++;
            end
            15: begin
               pop_exp(e);
               n_total++; if (hit_mask !== e.mask) $display("FAIL ovf_merged_mask: got %h want %h", hit_mask, e.mask); else n_pass++;
               n_total++; if (hit_time !== e.tim) $display("FAIL ovf_merged_time: got %h want %h", hit_time, e.tim); else n_pass++;
            end
            16: begin
               n_total++; if (hit_valid !== 1'b0) $display("FAIL ovf_no_double: got %b want 0", hit_valid); else n_pass++;
            end
            default: ;
         endcase
         @(negedge clk5); #1;
      end
   endtask

   task automatic test_back_to_back_wrap();
      exp_t e;
      do_reset();
      s = 4'b1111; en = 1'b1; hit_ready = 1'b1;
      wait_cnt(16'hFFFD);
      sb.push_back({4'b0001, 16'hFFFF});
      sb.push_back({4'b0010, 16'h0000});
      for (int k = 0; k < 5; k++) begin
         case (k)
            0: TDC_trigger = 4'b0001;
            1: TDC_trigger = 4'b0010;
            default: TDC_trigger = 4'b0000;
         endcase
         @(posedge clk5); #1;
         if (k == 2 || k == 3) begin
            pop_exp(e);
            n_total++; if (hit_valid !== 1'b1) $display("FAIL wrap_valid_%0d: got %b want 1", k, hit_valid); else n_pass++;
            n_total++; if (hit_mask !== e.mask) $display("FAIL wrap_mask_%0d: got %h want %h", k, hit_mask, e.mask); else n_pass++;
            n_total++; if (hit_time !== e.tim) $display("FAIL wrap_time_%0d: got %h want %h", k, hit_time, e.tim); else n_pass++;
         end
         if (k == 4) begin
            n_total++; if (hit_valid !== 1'b0) $display("FAIL wrap_drain: got %b want 0", hit_valid); else n_pass++;
         end
         @(negedge clk5); #1;
      end
   endtask

   task automatic test_reset_midop();
      logic seen;
      do_reset();
      s = 4'b1111; en = 1'b1; hit_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         case (k)
            0: TDC_trigger = 4'b0001;
            2: TDC_trigger = 4'b0010;
            default: TDC_trigger = 4'b0000;
         endcase
         @(posedge clk5); #1;
         @(negedge clk5); #1;
      end
      n_total++; if (hit_valid !== 1'b1) $display("FAIL midrst_pre_valid: got %b want 1", hit_valid); else n_pass++;
      @(posedge clk5); #3;
      rst_n = 1'b0;
      #1;
      n_total++; if (hit_valid !== 1'b0) $display("FAIL midrst_valid: got %b want 0", hit_valid); else n_pass++;
      n_total++; if (hit_mask !== 4'h0) $display("FAIL midrst_mask: got %h want 0", hit_mask); else n_pass++;
      n_total++; if (hit_time !== 16'h0) $display("FAIL midrst_time: got %h want 0", hit_time); else n_pass++;
      n_total++; if (ovf !== 4'h0) $display("FAIL midrst_ovf: got %h want 0", ovf); else n_pass++;
      @(negedge clk5); #1 rst_n = 1'b1;
      hit_ready = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk5); #1;
         if (hit_valid !== 1'b0) seen = 1'b1;
      end
      n_total++; if (seen !== 1'b0) $display("FAIL midrst_no_event: got %b want 0", seen); else n_pass++;
   endtask

   task automatic test_en_gate();
      logic seen;
      do_reset();
      s = 4'b1111; hit_ready = 1'b1;
      TDC_trigger = 4'b1000;
      seen = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk5); #1;
         if (hit_valid !== 1'b0) seen = 1'b1;
      end
      @(negedge clk5); #1 en = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk5); #1;
         if (hit_valid !== 1'b0) seen = 1'b1;
      end
      n_total++; if (seen !== 1'b0) $display("FAIL en_held_trigger: got %b want 0", seen); else n_pass++;
      @(negedge clk5); #1 TDC_trigger = 4'b0000;
   endtask

   initial begin
      rst_n = 1'b1; TDC_trigger = '0; s = '0; en = 1'b0; hit_ready = 1'b0; ovf_clr = 1'b0;
      #2;
      test_reset();
      test_posedge_phase();
      test_negedge_phase();
      test_backpressure();
      test_overflow();
      test_reset_midop();
      test_en_gate();
      test_back_to_back_wrap();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/tdc_sync_multi.md
# tdc_sync_multi

Parametrised multi-channel successor to the single-channel TDC stop synchroniser. Each channel samples its `TDC_trigger` on both edges of `clk5`, selects the phase with `s`, passes it through a configurable synchroniser chain and detects rising edges. A collector merges detected hits into a coarse-timestamped channel-mask event with a valid/ready handshake toward the TDC readout, and keeps sticky per-channel overflow flags.

## Interface
- `CH`, default 4: number of trigger channels (≥1).
- `SYNC_STAGES`, default 2: synchroniser depth (≥1).
  - Stage 1 is the negedge phase flop.
  - Stages 2..N are posedge flops.
- `CNT_W`, default 16: coarse counter and `hit_time` width.

Ports:
- `clk5`  in  1: the single clock. Its rising and falling edges are both used.
- `rst_n`  in  1: asynchronous, active-low reset.
- `TDC_trigger`  in  CH: raw stop/trigger per channel.
- `s`  in  CH: phase select per channel. 0 = negedge sample, 1 = posedge sample.
- `en`  in  1: enables the counter and hit capture.
- `sync`  out  CH: stage-1 phase-selected level (negedge flop), per channel.
- `hit_valid`  out  1: an event is presented.
- `hit_ready`  in  1: consumer accepts the event.
- `hit_mask`  out  CH: channels that hit in this event.
- `hit_time`  out  CNT_W: coarse time of the event.
- `ovf`  out  CH: sticky per-channel overflow flag.
- `ovf_clr`  in  1: clears all `ovf` bits.

## Operation
- Per-channel front end:
  - `stop_n` captures `TDC_trigger[i]` on the negedge; `stop_p` captures it on the posedge.
  - `vout = s[i] ? stop_p : stop_n`.
  - `sync[i]` registers `vout` on the negedge.
  - Stages `q2..qN` form a posedge shift chain. `qS` is `sync[i]` when `SYNC_STAGES=1`.
  - `qd` is `qS` delayed one posedge. `rise[i] = qS & ~qd`.
- Coarse counter `cnt`: CNT_W bits, +1 every posedge while `en`=1, wraps from all-ones to 0, holds while `en`=0.
- When `en`=0, `rise` is ignored and not accumulated. The pipeline keeps running, so a trigger that is already high when `en` rises produces no hit.
- Collector FSM (posedge), states IDLE and HOLD:
  - **IDLE**: if `en` and `rise`≠0, load `hit_mask`=`rise` and `hit_time`=`cnt` (value before increment). Raise `hit_valid` and go to HOLD.
  - **HOLD, no transfer**: OR new `rise` into `pend_mask`. When `pend_mask` goes from 0 to nonzero, latch `cnt` into `pend_time`.
  - **HOLD, transfer** (`hit_valid & hit_ready`): let `nxt = pend_mask | rise`.
    - If `nxt`≠0, load `hit_mask=nxt` and `hit_time = pend_mask≠0 ? pend_time : cnt`. Clear `pend_mask` and stay in HOLD with `hit_valid` held high.
    - Otherwise drop `hit_valid` and go to IDLE.
- `hit_mask`/`hit_time` stay stable while `hit_valid`=1 and `hit_ready`=0.
- `ovf[i]` sets when `rise[i]` arrives while `pend_mask[i]`=1, in HOLD with or without transfer. The hit is merged and not counted twice.
- `ovf_clr` clears all bits. If a set and `ovf_clr` occur in the same cycle, the set wins.

## Timing
- Reset (async): all flops are 0, including `sync`, `hit_valid`, `hit_mask`, `hit_time`, `ovf`, `cnt`, `pend_*`. FSM is in IDLE.
- Reset mid-operation discards the presented event and pending hits with no output glitch beyond the async clear.
- Latency, with the trigger rising before posedge P0:
  - `s=1`: `sync` high after N0 (P0+½). `hit_valid` high after P(SYNC_STAGES).
  - `s=0`: `sync` high after N1. `hit_valid` high after P(SYNC_STAGES+1).
- A single-cycle `TDC_trigger` pulse of ≥1 full period is always captured. Shorter pulses are not guaranteed.
- Back-to-back events: with `hit_ready` tied high, an event can be presented every cycle.

## Structure
- Package `tdc_pkg`:
  - collector state enum {IDLE, HOLD};
  - default parameter constants `TDC_CH`, `TDC_SYNC_STAGES`, `TDC_CNT_W`.
- Sub-module `tdc_sync_ch`: one channel's dual-edge sampler, phase mux, synchroniser chain and edge detect. Outputs are `sync` and `rise`. It is instantiated CH times in a generate loop.
- Collector, counter and overflow logic live in the top.

## Test plan
- Reset, then `en`=1, `s`=4'b1111, and ch0 rises before the posedge at `cnt`=5, `SYNC_STAGES`=2 → `hit_valid` after 2 posedges, `hit_mask`=4'b0001, `hit_time`=7.
- Same stimulus with `s[0]`=0 → `sync[0]` one cycle later than in the previous scenario, `hit_valid` one cycle later, `hit_time`=8.
- `hit_ready`=0; ch1 hits, then ch2 and ch3 hit 3 cycles later → first event mask 4'b0010 is held stable. On `hit_ready`=1, next cycle presents 4'b1100 with `pend_time`; `ovf`=0.
- While an event is held, ch2 hits twice → `ovf[2]`=1 and stays set. `ovf_clr` pulse → 0. `ovf_clr` in the same cycle as a new set → `ovf` stays 1.
- `cnt` preset near 16'hFFFF (run 65534 cycles) → a hit logs 16'hFFFF, and the next cycle's hit logs 16'h0000.
- Assert `rst_n` low while `hit_valid`=1 with pending hits → all outputs 0 immediately, no event after release. A trigger held high across `en` 0→1 → no hit.
